// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, constants and baud divider helper.
// UART_TX_PARITY_EN adds the PARITY state for 8-E-1 framing.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_tx_state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_tx_state_t;
`endif

    function automatic int uart_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO, wrap-bit pointers, no bypass.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         do_push, do_pop;

    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx_stim.sv
// uart_tx_stim: valid/ready byte FIFO feeding an 8-N-1 UART transmitter.
// Define UART_TX_PARITY_EN for 8-E-1 frames (even parity bit after data).
module uart_tx_stim
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_data,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int DIV = uart_div(CLK_FREQ_HZ, BAUD);
    localparam int CW  = $clog2(DIV);

    uart_tx_state_t            state, state_d;
    logic [CW-1:0]             cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift, head;
    logic                      rdy_en, full, empty, push, pop, tick, tx_d;
`ifdef UART_TX_PARITY_EN
    logic                      par;
`endif

    assign in_ready = rdy_en && !full;
    assign push     = in_valid && in_ready;
    assign tick     = cnt == CW'(DIV - 1);
    // Popping from STOP on its last cycle chains frames with no idle gap.
    assign pop      = !empty && (state == S_IDLE || (state == S_STOP && tick));

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(UART_DATA_BITS)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (in_data),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_comb begin
        state_d = state;
        tx_d    = (state == S_START) ? 1'b0 : (state == S_DATA) ? shift[0] : UART_IDLE_LEVEL;
        case (state)
            S_IDLE:   if (!empty) state_d = S_START;
            S_START:  if (tick) state_d = S_DATA;
`ifdef UART_TX_PARITY_EN
            S_DATA:   if (tick && bit_idx == 3'(UART_DATA_BITS - 1)) state_d = S_PARITY;
            S_PARITY: if (tick) state_d = S_STOP;
`else
            S_DATA:   if (tick && bit_idx == 3'(UART_DATA_BITS - 1)) state_d = S_STOP;
`endif
            S_STOP:   if (tick) state_d = empty ? S_IDLE : S_START;
            default:  state_d = S_IDLE;
        endcase
`ifdef UART_TX_PARITY_EN
        if (state == S_PARITY) tx_d = par;
`endif
    end

    // tx and busy both lag the state by one cycle, so they stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= UART_IDLE_LEVEL;
            busy    <= 1'b0;
            rdy_en  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state  <= state_d;
            tx     <= tx_d;
            busy   <= (state != S_IDLE) || !empty;
            rdy_en <= 1'b1;
            if (pop) begin
                shift   <= head;
                cnt     <= '0;
                bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                par     <= ^head;
`endif
            end else begin
                cnt <= tick ? '0 : cnt + 1'b1;
                if (tick && state == S_DATA) begin
                    shift   <= shift >> 1;
                    bit_idx <= bit_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_stim.sv
// tb_uart_tx_stim: directed checks on a default-rate instance and a fast (DIV=8) instance.
// Build with UART_TX_PARITY_EN to add the parity scenario.
module tb_uart_tx_stim;

    localparam int DIV0 = 868;
    localparam int DIV1 = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      v = '0;
    logic [1:0][7:0] d = '0;
    logic [1:0]      rdy, tx, busy;
    logic [1:0][4:0] lvl;
    int              cyc = 0;
    int              checks = 0;
    int              errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_stim dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v[0]), .in_ready(rdy[0]), .in_data(d[0]),
        .tx(tx[0]), .busy(busy[0]), .fifo_level(lvl[0])
    );

    uart_tx_stim #(.BAUD(12_500_000)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v[1]), .in_ready(rdy[1]), .in_data(d[1]),
        .tx(tx[1]), .busy(busy[1]), .fifo_level(lvl[1])
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push(input int s, input logic [7:0] b);
        @(negedge clk);
        v[s] = 1'b1;
        d[s] = b;
        @(posedge clk);
        #1 v[s] = 1'b0;
    endtask

    // Line-side decoder: finds the start edge, then samples mid-bit.
    task automatic recv(input int s, output logic [7:0] b, output logic p, output logic fr,
                        output int tf, output logic to);
        int dv, n;
        dv = s ? DIV1 : DIV0;
        b = '0; p = 1'b0; fr = 1'b0; tf = 0; to = 1'b0; n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx[s] !== 1'b0 && n < 30 * dv);
        if (tx[s] !== 1'b0) begin
            to = 1'b1;
            return;
        end
        tf = cyc;
        repeat (dv / 2) @(negedge clk);
        fr = (tx[s] === 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (dv) @(negedge clk);
            b[i] = tx[s];
        end
`ifdef UART_TX_PARITY_EN
        repeat (dv) @(negedge clk);
        p = tx[s];
`endif
        repeat (dv) @(negedge clk);
        fr = fr && (tx[s] === 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (tx[s] !== 1'b1 || rdy[s] !== 1'b0 || busy[s] !== 1'b0 || lvl[s] !== 5'd0) begin
                errors++;
                $display("FAIL reset_hold dut%0d: tx=%b rdy=%b busy=%b lvl=%0d expected tx=1 rdy=0 busy=0 lvl=0",
                         s, tx[s], rdy[s], busy[s], lvl[s]);
            end
        end
        rst_n = 1'b1;
        repeat (1000) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (tx[s] !== 1'b1 || rdy[s] !== 1'b1 || busy[s] !== 1'b0 || lvl[s] !== 5'd0) begin
                errors++;
                $display("FAIL reset_idle dut%0d: tx=%b rdy=%b busy=%b lvl=%0d expected tx=1 rdy=1 busy=0 lvl=0",
                         s, tx[s], rdy[s], busy[s], lvl[s]);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] b;
        logic p, fr, to;
        int k, tf;
        push(0, 8'hA5);
        k = cyc;
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || lvl[0] !== 5'd1) begin
            errors++;
            $display("FAIL single_after_push: busy=%b lvl=%0d expected busy=0 lvl=1", busy[0], lvl[0]);
        end
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1 || lvl[0] !== 5'd0 || tx[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_after_pop: busy=%b lvl=%0d tx=%b expected busy=1 lvl=0 tx=1",
                     busy[0], lvl[0], tx[0]);
        end
        recv(0, b, p, fr, tf, to);
        checks++;
        if (to || tf - k !== 2) begin
            errors++;
            $display("FAIL single_latency: timeout=%b latency=%0d expected timeout=0 latency=2", to, tf - k);
        end
        checks++;
        if (b !== 8'hA5 || fr !== 1'b1) begin
            errors++;
            $display("FAIL single_byte: got %h framing=%b expected a5 framing=1", b, fr);
        end
        while (cyc < tf + NB * DIV0 - 1) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_last: busy=%b expected 1", busy[0]);
        end
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || tx[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_end: busy=%b tx=%b expected busy=0 tx=1", busy[0], tx[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3] = '{8'h00, 8'hFF, 8'h55};
        logic [7:0] b;
        logic p, fr, to;
        int tf, tprev;
        tprev = 0;
        for (int i = 0; i < 3; i++) push(0, exp_b[i]);
        for (int i = 0; i < 3; i++) begin
            recv(0, b, p, fr, tf, to);
            checks++;
            if (to || b !== exp_b[i] || fr !== 1'b1) begin
                errors++;
                $display("FAIL b2b_byte%0d: got %h framing=%b timeout=%b expected %h framing=1",
                         i, b, fr, to, exp_b[i]);
            end
            if (i > 0) begin
                checks++;
                if (tf - tprev !== NB * DIV0) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d: got %0d expected %0d", i, tf - tprev, NB * DIV0);
                end
            end
            tprev = tf;
        end
        repeat (DIV0) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || tx[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b tx=%b expected busy=0 tx=1", busy[0], tx[0]);
        end
    endtask

    task automatic test_throttle();
        fork
            begin
                int acc, first_block;
                logic r;
                acc = 0;
                first_block = -1;
                for (int c = 0; c < 4000 && acc < 20; c++) begin
                    @(negedge clk);
                    d[1] = 8'(8'h30 + acc);
                    v[1] = 1'b1;
                    r = rdy[1];
                    if (!r && first_block < 0) begin
                        first_block = acc;
                        checks++;
                        if (lvl[1] !== 5'd16) begin
                            errors++;
                            $display("FAIL throttle_level: got %0d expected 16", lvl[1]);
                        end
                    end
                    @(posedge clk);
                    if (r) acc++;
                end
                #1 v[1] = 1'b0;
                checks++;
                if (first_block !== 17 || acc !== 20) begin
                    errors++;
                    $display("FAIL throttle_accepts: first_block=%0d accepted=%0d expected 17 and 20",
                             first_block, acc);
                end
            end
            begin
                logic [7:0] b;
                logic p, fr, to;
                int tf;
                for (int i = 0; i < 20; i++) begin
                    recv(1, b, p, fr, tf, to);
                    checks++;
                    if (to || b !== 8'(8'h30 + i) || fr !== 1'b1) begin
                        errors++;
                        $display("FAIL throttle_byte%0d: got %h framing=%b timeout=%b expected %h",
                                 i, b, fr, to, 8'(8'h30 + i));
                    end
                end
            end
        join
        repeat (DIV1) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        logic p, fr, to, bad;
        int tf, n;
        push(1, 8'h00);
        push(1, 8'h11);
        push(1, 8'h22);
        push(1, 8'h33);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx[1] !== 1'b0 && n < 100);
        tf = cyc;
        while (cyc < tf + 5 * DIV1 + DIV1 / 2) @(negedge clk);
        checks++;
        if (tx[1] !== 1'b0 || lvl[1] !== 5'd3) begin
            errors++;
            $display("FAIL rstmid_before: tx=%b lvl=%0d expected tx=0 lvl=3", tx[1], lvl[1]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx[1] !== 1'b1 || lvl[1] !== 5'd0 || busy[1] !== 1'b0 || rdy[1] !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: tx=%b lvl=%0d busy=%b rdy=%b expected tx=1 lvl=0 busy=0 rdy=0",
                     tx[1], lvl[1], busy[1], rdy[1]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (30 * DIV1) begin
            @(negedge clk);
            if (tx[1] !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad || lvl[1] !== 5'd0 || busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_quiet: tx_activity=%b lvl=%0d busy=%b expected 0 0 0", bad, lvl[1], busy[1]);
        end
        push(1, 8'h3C);
        recv(1, b, p, fr, tf, to);
        checks++;
        if (to || b !== 8'h3C || fr !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_resume: got %h framing=%b timeout=%b expected 3c", b, fr, to);
        end
        repeat (DIV1) @(negedge clk);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] b0, b1;
        logic p0, p1, fr, to0, to1;
        int tf0, tf1;
        push(1, 8'h07);
        push(1, 8'h03);
        recv(1, b0, p0, fr, tf0, to0);
        recv(1, b1, p1, fr, tf1, to1);
        checks++;
        if (to0 || b0 !== 8'h07 || p0 !== 1'b1) begin
            errors++;
            $display("FAIL parity_07: got %h parity=%b expected 07 parity=1", b0, p0);
        end
        checks++;
        if (to1 || b1 !== 8'h03 || p1 !== 1'b0) begin
            errors++;
            $display("FAIL parity_03: got %h parity=%b expected 03 parity=0", b1, p1);
        end
        checks++;
        if (tf1 - tf0 !== 11 * DIV1) begin
            errors++;
            $display("FAIL parity_frame: got %0d expected %0d", tf1 - tf0, 11 * DIV1);
        end
        repeat (DIV1) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_throttle();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
